mlp_layer_sequencer: RTL

- Controls a shared 8-neuron × 8-input layer datapath (int8 inputs, int16 outputs, valid_in/valid_out pulse) and reuses it over NUM_LAYERS layers of an emotion-classifier MLP.
- Accepts one int8 feature vector per inference, issues each layer in turn, requantizes the int16 outputs to int8 and feeds them back as the next layer's inputs.
- After the final layer, runs a sequential argmax and presents the winning class and its raw score.
- Sits between the feature front-end and the result/display logic.

---
 rtl/mlp_layer_sequencer_if.sv | 43 ++++
 rtl/mlp_layer_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mlp_layer_sequencer_if.sv
// Bus bundle between the MLP layer sequencer, the feature front-end, the
// shared layer datapath and the result consumer. master = sequencer side.
// Optional perf_cycles signal exists only when MLP_SEQ_PERF_EN is defined.
interface mlp_layer_sequencer_if;
  // feature input handshake
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_data;
  // shared layer datapath
  logic [1:0]   dp_layer_sel;
  logic         dp_valid_in;
  logic [63:0]  dp_x;
  logic [127:0] dp_y;
  logic         dp_valid_out;
  // result handshake
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_class;
  logic [15:0]  out_score;
  logic         out_err;
  logic         busy;
`ifdef MLP_SEQ_PERF_EN
  logic [15:0]  perf_cycles;
`endif

  modport master (
    input  in_valid, in_data, dp_y, dp_valid_out, out_ready,
    output in_ready, dp_layer_sel, dp_valid_in, dp_x,
           out_valid, out_class, out_score, out_err, busy
`ifdef MLP_SEQ_PERF_EN
    , output perf_cycles
`endif
  );

  modport slave (
    output in_valid, in_data, dp_y, dp_valid_out, out_ready,
    input  in_ready, dp_layer_sel, dp_valid_in, dp_x,
           out_valid, out_class, out_score, out_err, busy
`ifdef MLP_SEQ_PERF_EN
    , input perf_cycles
`endif
  );
endinterface

// File: rtl/mlp_layer_sequencer.sv
// Purpose: reuses one 8x8 layer datapath over NUM_LAYERS passes, requantizes between layers, argmax at the end.
// Latency: out_valid in cycle 1 + NUM_LAYERS*(L+2) + 8 after accept (L = datapath latency); timeout ends early with out_err.
// Backpressure: single inference in flight; in_ready only in IDLE, result held in OUT until out_ready. MLP_SEQ_PERF_EN adds perf_cycles.
module mlp_layer_sequencer #(
  parameter int NUM_LAYERS = 3,
  parameter int SHIFT      = 7,
  parameter int DP_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  mlp_layer_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    REQUANT = 3'd3,
    ARGMAX  = 3'd4,
    OUT     = 3'd5
  } state_t;

  state_t       state_q, state_d;
  logic [63:0]  x_q, x_d;
  logic [127:0] y_q, y_d;
  logic [1:0]   layer_q, layer_d;
  logic [15:0]  tmo_q, tmo_d;
  logic [3:0]   idx_q, idx_d;
  logic [15:0]  best_q, best_d;
  logic [2:0]   best_idx_q, best_idx_d;
  logic [2:0]   class_q, class_d;
  logic [15:0]  score_q, score_d;
  logic         err_q, err_d;
  logic [63:0]  x_requant;
  logic [15:0]  y_word;

  // Arithmetic shift then clamp to the int8 range.
  function automatic logic [7:0] requant(input logic [15:0] y);
    logic signed [15:0] t;
    t = $signed(y) >>> SHIFT;
    if (t > 16'sd127)       return 8'h7F;
    else if (t < -16'sd128) return 8'h80;
    else                    return t[7:0];
  endfunction

  // Requantized next-layer input vector from the captured datapath outputs.
  always_comb begin
    x_requant = '0;
    for (int i = 0; i < 8; i++) begin
      x_requant[8*i +: 8] = requant(y_q[16*i +: 16]);
    end
  end

  // Output word currently visited by the argmax scan (idx 8 aliases word 0, unused then).
  assign y_word = y_q[{idx_q[2:0], 4'd0} +: 16];

  // Next-state and datapath-register update logic.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    layer_d    = layer_q;
    tmo_d      = tmo_q;
    idx_d      = idx_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    class_d    = class_q;
    score_d    = score_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          x_d     = bus.in_data;
          layer_d = 2'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.dp_valid_out) begin
          y_d     = bus.dp_y;
          state_d = REQUANT;
        end else if (tmo_q == 16'(DP_TIMEOUT - 1)) begin
          class_d = '0;
          score_d = '0;
          err_d   = 1'b1;
          state_d = OUT;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      REQUANT: begin
        // x only changes on the edge into ISSUE so dp_x stays stable between issues.
        if (layer_q < 2'(NUM_LAYERS - 1)) begin
          x_d     = x_requant;
          layer_d = layer_q + 2'd1;
          state_d = ISSUE;
        end else begin
          idx_d      = 4'd1;
          best_idx_d = 3'd0;
          best_d     = y_q[15:0];
          state_d    = ARGMAX;
        end
      end
      ARGMAX: begin
        if (idx_q == 4'd8) begin
          class_d = best_idx_q;
          score_d = best_q;
          err_d   = 1'b0;
          state_d = OUT;
        end else begin
          // Strict compare: ties keep the lower index.
          if ($signed(y_word) > $signed(best_q)) begin
            best_d     = y_word;
            best_idx_d = idx_q[2:0];
          end
          idx_d = idx_q + 4'd1;
        end
      end
      OUT: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and working registers; reset aborts any inference in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      layer_q    <= '0;
      tmo_q      <= '0;
      idx_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      class_q    <= '0;
      score_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      layer_q    <= layer_d;
      tmo_q      <= tmo_d;
      idx_q      <= idx_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      class_q    <= class_d;
      score_q    <= score_d;
      err_q      <= err_d;
    end
  end

  // in_ready is gated by reset so it reads 0 while reset is held.
  assign bus.in_ready     = (state_q == IDLE) && reset;
  assign bus.dp_valid_in  = (state_q == ISSUE);
  assign bus.dp_x         = x_q;
  assign bus.dp_layer_sel = layer_q;
  assign bus.out_valid    = (state_q == OUT);
  assign bus.out_class    = class_q;
  assign bus.out_score    = score_q;
  assign bus.out_err      = err_q;
  assign bus.busy         = (state_q != IDLE);

`ifdef MLP_SEQ_PERF_EN
  logic [15:0] perf_cnt_q, perf_cnt_d;
  logic [15:0] perf_q, perf_d;
  logic [15:0] perf_inc;

  assign perf_inc = (perf_cnt_q == 16'hFFFF) ? perf_cnt_q : perf_cnt_q + 16'd1;

  // Cycle count from accept (cycle 1 = ISSUE) latched on the edge into OUT.
  always_comb begin
    perf_cnt_d = perf_cnt_q;
    perf_d     = perf_q;
    if (state_q == IDLE && bus.in_valid) begin
      perf_cnt_d = 16'd1;
    end else if (state_q != IDLE && state_q != OUT) begin
      perf_cnt_d = perf_inc;
    end
    if (state_q != OUT && state_d == OUT) begin
      perf_d = perf_inc;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_cnt_q <= '0;
      perf_q     <= '0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
      perf_q     <= perf_d;
    end
  end

  assign bus.perf_cycles = perf_q;
`endif

endmodule
